// File: rtl/bist_scan_controller.sv
// ---------------------------------------------------------------------------
// bist_scan_controller
//
// Runs one complete BIST session on an LFSR-fed scan CUT. On START the CUT is
// reseeded for one cycle. The first pattern is then shifted in with SE=1 while
// SO is ignored, because the chain still holds reset data. Each pattern is
// captured in a single SE=0 cycle. Every following shift round unloads the
// previous response while it loads the next pattern. A final unload round
// drains the last response. Every unloaded SO bit is folded into a
// serial-input signature register (SISR). When the session ends, the SISR is
// compared against a golden signature.
//
// Ports:
//   CLK          rising-edge clock
//   RST          asynchronous active-high reset; aborts any session
//   START        session request, only honoured in IDLE or DONE
//   SO           scan-out bit from the CUT
//   SE           scan enable to the CUT (1 = shift, 0 = capture)
//   CUT_RST      one-cycle reseed/clear pulse to the CUT
//   BUSY         session in progress
//   DONE         session complete; held until the next START or RST
//   PASS         valid while DONE: SIGNATURE == GOLDEN_SIG
//   SIGNATURE    current SISR contents
//   PATTERN_CNT  number of patterns captured so far in this session
//
// All outputs are registered. Outputs are Moore-style and are updated on the
// same edge as the state they belong to.
// ---------------------------------------------------------------------------
module bist_scan_controller #(
  parameter int                    CHAIN_LEN    = 4,
  parameter int                    NUM_PATTERNS = 32,
  parameter int                    SIG_WIDTH    = 16,
  parameter logic [SIG_WIDTH-1:0]  SIG_POLY     = 16'h1021,
  parameter logic [SIG_WIDTH-1:0]  GOLDEN_SIG   = 16'h0000,
  localparam int                   CNT_W        = $clog2(NUM_PATTERNS + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 SO,
  output logic                 SE,
  output logic                 CUT_RST,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PASS,
  output logic [SIG_WIDTH-1:0] SIGNATURE,
  output logic [CNT_W-1:0]     PATTERN_CNT
);

  // The shift counter needs at least one bit, even for a one-flop chain.
  localparam int SH_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

  localparam logic [SH_W-1:0]  SHIFT_LAST   = SH_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] PATTERN_LAST = CNT_W'(NUM_PATTERNS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LOAD,
    S_CAPTURE,
    S_SHIFT,
    S_UNLOAD,
    S_DONE
  } state_t;

  state_t          state;
  logic [SH_W-1:0] shift_cnt;
  logic            shift_last;
  logic            pattern_last;
  logic            sig_fb;
  logic [SIG_WIDTH-1:0] sig_next;

  assign shift_last   = (shift_cnt == SHIFT_LAST);
  // The count before this capture is one short of the total, so this
  // capture is the final one.
  assign pattern_last = (PATTERN_CNT == PATTERN_LAST);

  // Next SISR value when one SO bit is compacted. The SISR register is only
  // loaded with this value in SHIFT and UNLOAD. The value is also used when
  // entering DONE, so PASS is decided on the final signature without an
  // extra cycle of latency.
  always_comb begin
    sig_fb   = SIGNATURE[SIG_WIDTH-1] ^ SO;
    sig_next = {SIGNATURE[SIG_WIDTH-2:0], 1'b0};
    if (sig_fb) begin
      sig_next = sig_next ^ SIG_POLY;
    end
  end

  // Session FSM and all registered outputs. LOAD, SHIFT and UNLOAD each last
  // CHAIN_LEN cycles, counted by shift_cnt. The counter returns to 0 whenever
  // one of those states is left. PATTERN_CNT never passes NUM_PATTERNS,
  // because CAPTURE is only entered while patterns remain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      shift_cnt   <= '0;
      SE          <= 1'b0;
      CUT_RST     <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      PASS        <= 1'b0;
      SIGNATURE   <= '0;
      PATTERN_CNT <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            state       <= S_INIT;
            shift_cnt   <= '0;
            SE          <= 1'b0;
            CUT_RST     <= 1'b1;
            BUSY        <= 1'b1;
            DONE        <= 1'b0;
            PASS        <= 1'b0;
            SIGNATURE   <= '0;
            PATTERN_CNT <= '0;
          end
        end

        S_INIT: begin
          state     <= S_LOAD;
          CUT_RST   <= 1'b0;
          SE        <= 1'b1;
          shift_cnt <= '0;
        end

        // The first pattern goes in here. SO only carries the post-reset
        // chain contents, so it is not compacted.
        S_LOAD: begin
          if (shift_last) begin
            state     <= S_CAPTURE;
            SE        <= 1'b0;
            shift_cnt <= '0;
          end else begin
            shift_cnt <= shift_cnt + 1'b1;
          end
        end

        S_CAPTURE: begin
          PATTERN_CNT <= PATTERN_CNT + 1'b1;
          SE          <= 1'b1;
          shift_cnt   <= '0;
          if (pattern_last) begin
            state <= S_UNLOAD;
          end else begin
            state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          SIGNATURE <= sig_next;
          if (shift_last) begin
            state     <= S_CAPTURE;
            SE        <= 1'b0;
            shift_cnt <= '0;
          end else begin
            shift_cnt <= shift_cnt + 1'b1;
          end
        end

        S_UNLOAD: begin
          SIGNATURE <= sig_next;
          if (shift_last) begin
            state     <= S_DONE;
            SE        <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b1;
            PASS      <= (sig_next == GOLDEN_SIG);
            shift_cnt <= '0;
          end else begin
            shift_cnt <= shift_cnt + 1'b1;
          end
        end

        default: begin
          state       <= S_IDLE;
          shift_cnt   <= '0;
          SE          <= 1'b0;
          CUT_RST     <= 1'b0;
          BUSY        <= 1'b0;
          DONE        <= 1'b0;
          PASS        <= 1'b0;
          SIGNATURE   <= '0;
          PATTERN_CNT <= '0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // The CUT must never be shifting while it is being reseeded.
  a_no_se_during_reseed : assert property (@(posedge CLK) disable iff (RST)
    !(SE && CUT_RST));

  // BUSY and DONE describe mutually exclusive phases of a session.
  a_busy_done_exclusive : assert property (@(posedge CLK) disable iff (RST)
    !(BUSY && DONE));

  // A PASS verdict only exists while the session result is being presented.
  a_pass_only_when_done : assert property (@(posedge CLK) disable iff (RST)
    PASS |-> DONE);
`endif

endmodule

// File: tb/tb_bist_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_bist_scan_controller
//
// Directed bench for bist_scan_controller with default parameters. A table of
// SO patterns is run as full sessions. Every cycle is checked against the
// expected SE / CUT_RST / BUSY / DONE / PATTERN_CNT timeline. The final
// signature and PASS are checked against hand-computed values.
//
// A second instance uses GOLDEN_SIG = 16'h1021. It checks that PASS really
// compares against the golden value.
//
// Hand-written sequences cover the following cases:
//   - reset at power-up
//   - abort mid-session
//   - START held high across a whole session
// ---------------------------------------------------------------------------
module tb_bist_scan_controller;

  localparam int CL    = 4;
  localparam int NP    = 32;
  // INIT + LOAD + NP captures + (NP-1) shift rounds + UNLOAD
  localparam int TOTAL = 1 + CL + NP + (NP - 1) * CL + CL;

  logic        CLK;
  logic        RST;
  logic        START;
  logic        SO;
  logic        se;
  logic        cut_rst;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [5:0]  pattern_cnt;
  logic        g_se;
  logic        g_cut_rst;
  logic        g_busy;
  logic        g_done;
  logic        g_pass;
  logic [15:0] g_signature;
  logic [5:0]  g_pattern_cnt;

  int vectors_applied = 0;
  int miscompares     = 0;

  bist_scan_controller dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .SO          (SO),
    .SE          (se),
    .CUT_RST     (cut_rst),
    .BUSY        (busy),
    .DONE        (done),
    .PASS        (pass),
    .SIGNATURE   (signature),
    .PATTERN_CNT (pattern_cnt)
  );

  bist_scan_controller #(.GOLDEN_SIG(16'h1021)) dut_gold (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .SO          (SO),
    .SE          (g_se),
    .CUT_RST     (g_cut_rst),
    .BUSY        (g_busy),
    .DONE        (g_done),
    .PASS        (g_pass),
    .SIGNATURE   (g_signature),
    .PATTERN_CNT (g_pattern_cnt)
  );

  // 100 MHz-style free-running clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Session vectors. Mode 1 raises SO on cycles a/b only. Mode 2 raises SO
  // only on LOAD and CAPTURE cycles. Mode 3 drives a deterministic
  // pseudo-random SO stream.
  typedef struct {
    string       name;
    int          mode;
    int          a;
    int          b;
    logic [15:0] exp_sig;
    logic        exp_pass;
    logic        exp_pass_g;
  } vec_t;

  vec_t vec [8];

  // Cycle c of a session is the cycle that ends at edge c.
  function automatic bit isCapture(input int c);
    return (c >= CL + 2) && (c <= TOTAL - CL) && (((c - (CL + 2)) % (CL + 1)) == 0);
  endfunction

  function automatic bit isCompact(input int c);
    return (c > CL + 2) && (c <= TOTAL) && !isCapture(c);
  endfunction

  function automatic logic expSe(input int c);
    return !((c == 1) || isCapture(c));
  endfunction

  function automatic int expCnt(input int c);
    int n;
    n = (c > CL + 2) ? ((c - (CL + 3)) / (CL + 1) + 1) : 0;
    return (n > NP) ? NP : n;
  endfunction

  function automatic logic soRand(input int c);
    return logic'(((c * 7) ^ (c >> 2) ^ (c / 3)) & 1);
  endfunction

  function automatic logic soFor(input int idx, input int c);
    case (vec[idx].mode)
      1:       return (c == vec[idx].a) || (c == vec[idx].b);
      2:       return ((c >= 2) && (c <= CL + 1)) || isCapture(c);
      3:       return soRand(c);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] modelSig(input int idx);
    logic [15:0] s;
    logic        fb;
    s = 16'h0000;
    for (int c = 1; c <= TOTAL; c++) begin
      if (isCompact(c)) begin
        fb = s[15] ^ soFor(idx, c);
        s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return s;
  endfunction

  // Drives inputs on the falling edge. DUT outputs are registered, so they
  // can be sampled right afterwards in the same half-cycle.
  task automatic applyStimulus(input logic start_v, input logic so_v);
    @(negedge CLK);
    START = start_v;
    SO    = so_v;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_se"},      se,          0);
    checkOutput({tag, "_cut_rst"}, cut_rst,     0);
    checkOutput({tag, "_busy"},    busy,        0);
    checkOutput({tag, "_done"},    done,        0);
    checkOutput({tag, "_pass"},    pass,        0);
    checkOutput({tag, "_sig"},     signature,   0);
    checkOutput({tag, "_cnt"},     pattern_cnt, 0);
  endtask

  // Runs one session with vector idx. With skip_start set, the START edge
  // has already happened, as when START is held across DONE.
  task automatic runSession(input int idx, input bit hold, input bit skip_start);
    if (!skip_start) begin
      applyStimulus(1'b1, 1'b0);
      @(posedge CLK);
    end
    for (int c = 1; c <= TOTAL; c++) begin
      applyStimulus(hold, soFor(idx, c));
      checkOutput("se",      se,          expSe(c));
      checkOutput("cut_rst", cut_rst,     c == 1);
      checkOutput("busy",    busy,        1);
      checkOutput("done",    done,        0);
      checkOutput("pat_cnt", pattern_cnt, expCnt(c));
      if (c <= CL + 3) begin
        checkOutput("sig_clear", signature, 0);
        checkOutput("pass_clr",  pass,      0);
      end
    end
    applyStimulus(hold, 1'b0);
    checkOutput({vec[idx].name, "_done"},   done,        1);
    checkOutput({vec[idx].name, "_busy"},   busy,        0);
    checkOutput({vec[idx].name, "_se"},     se,          0);
    checkOutput({vec[idx].name, "_cnt"},    pattern_cnt, NP);
    checkOutput({vec[idx].name, "_sig"},    signature,   vec[idx].exp_sig);
    checkOutput({vec[idx].name, "_pass"},   pass,        vec[idx].exp_pass);
    checkOutput({vec[idx].name, "_gpass"},  g_pass,      vec[idx].exp_pass_g);
  endtask

  initial begin
    bit seen;

    vec[0] = '{"zeros",      1, 0,   0,   16'h0000, 1'b1, 1'b0};
    vec[1] = '{"masked",     2, 0,   0,   16'h0000, 1'b1, 1'b0};
    vec[2] = '{"last_unld",  1, 165, 0,   16'h1021, 1'b0, 1'b1};
    vec[3] = '{"prev_unld",  1, 164, 0,   16'h2042, 1'b0, 1'b0};
    vec[4] = '{"first_unld", 1, 162, 0,   16'h8108, 1'b0, 1'b0};
    vec[5] = '{"last_shift", 1, 160, 0,   16'h1231, 1'b0, 1'b0};
    vec[6] = '{"two_bits",   1, 164, 165, 16'h3063, 1'b0, 1'b0};
    vec[7] = '{"random",     3, 0,   0,   16'h0000, 1'b0, 1'b0};
    vec[7].exp_sig    = modelSig(7);
    vec[7].exp_pass   = (vec[7].exp_sig == 16'h0000);
    vec[7].exp_pass_g = (vec[7].exp_sig == 16'h1021);

    // Power-up reset
    RST   = 1'b1;
    START = 1'b0;
    SO    = 1'b0;
    repeat (2) @(negedge CLK);
    checkResetValues("por");
    RST = 1'b0;

    // Table-driven sessions
    for (int i = 0; i < 8; i++) begin
      runSession(i, 1'b0, 1'b0);
    end

    // Abort mid-SHIFT after pattern 10, then make sure no DONE follows
    applyStimulus(1'b1, 1'b0);
    @(posedge CLK);
    for (int c = 1; c <= 52; c++) begin
      applyStimulus(1'b0, soRand(c));
    end
    @(negedge CLK);
    checkOutput("abort_cnt", pattern_cnt, 10);
    checkOutput("abort_se",  se,          1);
    RST = 1'b1;
    #1;
    checkResetValues("abort");
    @(negedge CLK);
    RST  = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < TOTAL + 10; c++) begin
      applyStimulus(1'b0, 1'b0);
      if (done || busy) seen = 1'b1;
    end
    checkOutput("no_done_after_abort", seen, 0);
    runSession(0, 1'b0, 1'b0);

    // START held high: no restart while BUSY, DONE lasts exactly one cycle,
    // and the next session starts with a cleared SISR
    runSession(2, 1'b1, 1'b0);
    runSession(5, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
